krnl_partialknn_sp_loader: RTL and testbench
============================================

KRNL_PARTIALKNN_SP_LOADER -- requirements
Module: krnl_partialknn_sp_loader

Interface
REQ-001 Parameters SHALL be, one per line:
  DataWidth, 256, beat width
  AddressRange, 2048, local buffer depth
  AddressWidth, 11, buffer address width
REQ-002 Ports SHALL be, one per line:
  ap_clk  in  1  single clock; all logic on rising edge
  ap_rst_n  in  1  synchronous, active-low reset
  start  in  1  one-cycle job request
  num_beats  in  12  beats to load; captured on accepted start
  passes  in  8  read-back passes; captured on accepted start
  busy  out  1  high from accepted start until done
  done  out  1  one-cycle completion pulse
  s_tdata  in  DataWidth  load stream data
  s_tvalid  in  1  load stream valid
  s_tready  out  1  load stream ready
  m_tdata  out  DataWidth  read-back stream data
  m_tvalid  out  1  read-back valid
  m_tready  in  1  read-back ready
  m_tlast  out  1  last beat of each pass
  mem_address0  out  AddressWidth  buffer address
  mem_ce0  out  1  buffer enable
  mem_we0  out  1  buffer write enable
  mem_d0  out  DataWidth  buffer write data
  mem_q0  in  DataWidth  buffer read data, valid one cycle after read enable

Function
REQ-003 States SHALL be IDLE, LOAD, READ, FLUSH, DONE.
REQ-004 IDLE: start with 1<=num_beats<=2048 and passes>=1 SHALL capture both, assert busy next cycle, and enter LOAD.
REQ-005 IDLE: start with num_beats==0, num_beats>2048 or passes==0 SHALL pulse done the next cycle, leave busy low, and stay in IDLE.
REQ-006 start SHALL be ignored whenever busy is high.
REQ-007 s_tready SHALL be high only in LOAD; every s_tvalid&&s_tready cycle SHALL drive mem_ce0=1, mem_we0=1, mem_address0=write count, mem_d0=s_tdata combinationally in that cycle.
REQ-008 Write count SHALL start at 0 and increment per handshake; after handshake num_beats the next state SHALL be READ with s_tready low.
REQ-009 READ: a read (mem_ce0=1, mem_we0=0, mem_address0=read address) SHALL be issued only when FIFO occupancy plus in-flight reads is less than 2.
REQ-010 Read data SHALL be pushed into a 2-entry output FIFO the cycle after issue; m_tvalid SHALL equal FIFO non-empty; m_tdata/m_tlast SHALL come from the FIFO head.
REQ-011 Push and pop in the same cycle SHALL both take effect with no stall and no loss.
REQ-012 While m_tvalid&&!m_tready, m_tdata and m_tlast SHALL hold stable.
REQ-013 m_tlast SHALL be high on the beat read from address num_beats-1 in every pass.
REQ-014 Read address SHALL wrap to 0 after num_beats-1, and the pass count SHALL then increment; after the last read of pass passes, the next state SHALL be FLUSH.
REQ-015 FLUSH SHALL issue no reads and SHALL move to DONE once no read is in flight and the FIFO is empty.
REQ-016 DONE SHALL assert done for exactly one cycle, drop busy in the same cycle, and return to IDLE.
REQ-017 mem_ce0 and mem_we0 SHALL be low in IDLE, FLUSH and DONE; no memory read and write SHALL occur in the same cycle.
REQ-018 Total m_ handshakes per job SHALL equal num_beats*passes, with data order equal to load order repeated once per pass.

Reset
REQ-019 While ap_rst_n is low at a clock edge, the block SHALL enter IDLE and clear counters, FIFO and in-flight state.
REQ-020 Reset values SHALL be: busy=0, done=0, s_tready=0, m_tvalid=0, m_tlast=0, mem_ce0=0, mem_we0=0, mem_address0=0, mem_d0=0, m_tdata=0.
REQ-021 Reset mid-job SHALL abandon the job with no done pulse; buffer contents are not cleared.

Verification
REQ-022 Load 4 beats D0..D3, passes=2, m_tready=1 -> writes to addresses 0..3, output D0,D1,D2,D3,D0,D1,D2,D3, m_tlast on beats 4 and 8, then one done pulse.
REQ-023 num_beats=2048, passes=1, random m_tready at 30% -> 2048 ordered beats, no drop or duplicate, m_tdata stable while stalled.
REQ-024 start with num_beats=0 -> done next cycle, busy stays 0, no memory access.
REQ-025 start pulsed again during LOAD with num_beats=5 -> ignored; original job completes with its own count and passes.
REQ-026 ap_rst_n low for 1 cycle during READ pass 1 of 3 -> all outputs at reset values next cycle, no done; a new job with num_beats=1, passes=1 then completes normally.
REQ-027 m_tready held low for 10 cycles in READ -> at most 2 reads outstanding or buffered; streaming resumes in order when ready returns.

Source files
------------

// File: rtl/krnl_partialknn_sp_loader.sv
// Loads a stream of beats into a local single-port buffer, then replays the
// buffer a programmed number of passes through a 2-entry skid FIFO.
module krnl_partialknn_sp_loader #(
   parameter int DataWidth    = 256,
   parameter int AddressRange = 2048,
   parameter int AddressWidth = 11
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    start,
   input  logic [11:0]             num_beats,
   input  logic [7:0]              passes,
   output logic                    busy,
   output logic                    done,
   input  logic [DataWidth-1:0]    s_tdata,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   output logic [DataWidth-1:0]    m_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic [AddressWidth-1:0] mem_address0,
   output logic                    mem_ce0,
   output logic                    mem_we0,
   output logic [DataWidth-1:0]    mem_d0,
   input  logic [DataWidth-1:0]    mem_q0
);

   localparam int CntWidth = 12;
   localparam logic [CntWidth-1:0] MaxBeats = CntWidth'(AddressRange);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READ,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CntWidth-1:0]   nb_q, nb_d;
   logic [7:0]            passes_q, passes_d;
   logic [CntWidth-1:0]   wr_cnt_q, wr_cnt_d;
   logic [CntWidth-1:0]   rd_addr_q, rd_addr_d;
   logic [7:0]            pass_cnt_q, pass_cnt_d;
   logic                  pend_q, pend_d;
   logic                  pend_last_q, pend_last_d;
   logic                  rej_q, rej_d;
   logic [DataWidth-1:0]  fifo_data_q [2];
   logic [DataWidth-1:0]  fifo_data_d [2];
   logic [1:0]            fifo_last_q, fifo_last_d;
   logic                  fifo_wp_q, fifo_wp_d;
   logic                  fifo_rp_q, fifo_rp_d;
   logic [1:0]            fifo_cnt_q, fifo_cnt_d;

   logic start_ok;
   logic s_hs;
   logic pop;
   logic rd_issue;
   logic rd_wrap;

   always_comb begin
      start_ok = (num_beats != '0) && (num_beats <= MaxBeats) && (passes != '0);
      s_hs     = (state_q == S_LOAD) && s_tvalid;
      pop      = (fifo_cnt_q != 2'd0) && m_tready;
      // Reads only launch when a landing slot is guaranteed, ignoring a same-cycle pop.
      rd_issue = (state_q == S_READ) &&
                 (({1'b0, fifo_cnt_q} + {2'b00, pend_q}) < 3'd2);
      rd_wrap  = (rd_addr_q == nb_q - 12'd1);
   end

   always_comb begin
      busy     = (state_q == S_LOAD) || (state_q == S_READ) || (state_q == S_FLUSH);
      done     = (state_q == S_DONE) || rej_q;
      s_tready = (state_q == S_LOAD);
      m_tvalid = (fifo_cnt_q != 2'd0);
      m_tdata  = fifo_data_q[fifo_rp_q];
      m_tlast  = fifo_last_q[fifo_rp_q];

      mem_ce0      = 1'b0;
      mem_we0      = 1'b0;
      mem_address0 = '0;
      mem_d0       = '0;
      if (s_hs) begin
         mem_ce0      = 1'b1;
         mem_we0      = 1'b1;
         mem_address0 = wr_cnt_q[AddressWidth-1:0];
         mem_d0       = s_tdata;
      end else if (rd_issue) begin
         mem_ce0      = 1'b1;
         mem_address0 = rd_addr_q[AddressWidth-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      nb_d        = nb_q;
      passes_d    = passes_q;
      wr_cnt_d    = wr_cnt_q;
      rd_addr_d   = rd_addr_q;
      pass_cnt_d  = pass_cnt_q;
      rej_d       = 1'b0;
      pend_d      = rd_issue;
      pend_last_d = rd_issue && rd_wrap;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_ok) begin
                  nb_d     = num_beats;
                  passes_d = passes;
                  wr_cnt_d = '0;
                  state_d  = S_LOAD;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (s_hs) begin
               wr_cnt_d = wr_cnt_q + 12'd1;
               if (wr_cnt_q == nb_q - 12'd1) begin
                  rd_addr_d  = '0;
                  pass_cnt_d = '0;
                  state_d    = S_READ;
               end
            end
         end
         S_READ: begin
            if (rd_issue) begin
               if (rd_wrap) begin
                  rd_addr_d = '0;
                  if (pass_cnt_q == passes_q - 8'd1) begin
                     state_d = S_FLUSH;
                  end else begin
                     pass_cnt_d = pass_cnt_q + 8'd1;
                  end
               end else begin
                  rd_addr_d = rd_addr_q + 12'd1;
               end
            end
         end
         S_FLUSH: begin
            if (!pend_q && (fifo_cnt_q == 2'd0)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Memory returns data one cycle after issue; that beat is pushed straight into the FIFO.
   always_comb begin
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      fifo_wp_d   = fifo_wp_q;
      fifo_rp_d   = fifo_rp_q;
      if (pend_q) begin
         fifo_data_d[fifo_wp_q] = mem_q0;
         fifo_last_d[fifo_wp_q] = pend_last_q;
         fifo_wp_d              = ~fifo_wp_q;
      end
      if (pop) begin
         fifo_rp_d = ~fifo_rp_q;
      end
      fifo_cnt_d = fifo_cnt_q + {1'b0, pend_q} - {1'b0, pop};
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q        <= S_IDLE;
         nb_q           <= '0;
         passes_q       <= '0;
         wr_cnt_q       <= '0;
         rd_addr_q      <= '0;
         pass_cnt_q     <= '0;
         pend_q         <= 1'b0;
         pend_last_q    <= 1'b0;
         rej_q          <= 1'b0;
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_last_q    <= '0;
         fifo_wp_q      <= 1'b0;
         fifo_rp_q      <= 1'b0;
         fifo_cnt_q     <= '0;
      end else begin
         state_q     <= state_d;
         nb_q        <= nb_d;
         passes_q    <= passes_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_addr_q   <= rd_addr_d;
         pass_cnt_q  <= pass_cnt_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         rej_q       <= rej_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         fifo_wp_q   <= fifo_wp_d;
         fifo_rp_q   <= fifo_rp_d;
         fifo_cnt_q  <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_krnl_partialknn_sp_loader.sv
// Directed-plus-random bench: jobs are described by their beat list, and the
// expected output is that list repeated once per pass.
module tb_krnl_partialknn_sp_loader;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n;
   logic         start;
   logic [11:0]  num_beats;
   logic [7:0]   passes;
   logic         busy;
   logic         done;
   logic [255:0] s_tdata;
   logic         s_tvalid;
   logic         s_tready;
   logic [255:0] m_tdata;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;
   logic [10:0]  mem_address0;
   logic         mem_ce0;
   logic         mem_we0;
   logic [255:0] mem_d0;
   logic [255:0] mem_q0;

   logic [255:0] mem [0:2047];

   int compared   = 0;
   int mismatched = 0;

   logic [255:0] exp_q[$];
   bit           exp_last_q[$];

   krnl_partialknn_sp_loader dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .start        (start),
      .num_beats    (num_beats),
      .passes       (passes),
      .busy         (busy),
      .done         (done),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready),
      .m_tlast      (m_tlast),
      .mem_address0 (mem_address0),
      .mem_ce0      (mem_ce0),
      .mem_we0      (mem_we0),
      .mem_d0       (mem_d0),
      .mem_q0       (mem_q0)
   );

   always #5 ap_clk = ~ap_clk;

   // Single-port buffer with one-cycle read latency.
   always @(posedge ap_clk) begin
      if (mem_ce0) begin
         if (mem_we0) mem[mem_address0] <= mem_d0;
         else         mem_q0 <= mem[mem_address0];
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk_reset_values(input string ctx);
      chk({ctx, "_busy"},     busy,         0);
      chk({ctx, "_done"},     done,         0);
      chk({ctx, "_s_tready"}, s_tready,     0);
      chk({ctx, "_m_tvalid"}, m_tvalid,     0);
      chk({ctx, "_m_tlast"},  m_tlast,      0);
      chk({ctx, "_mem_ce0"},  mem_ce0,      0);
      chk({ctx, "_mem_we0"},  mem_we0,      0);
      chk({ctx, "_mem_addr"}, mem_address0, 0);
      chk({ctx, "_mem_d0"},   mem_d0,       0);
      chk({ctx, "_m_tdata"},  m_tdata,      0);
   endtask

   task automatic reject_start(input int nb, input int np);
      @(negedge ap_clk);
      start = 1'b1; num_beats = 12'(nb); passes = 8'(np);
      #1;
      chk("rej_busy_req", busy, 0);
      @(negedge ap_clk);
      start = 1'b0;
      #1;
      chk("rej_done", done, 1);
      chk("rej_busy", busy, 0);
      chk("rej_ce", mem_ce0, 0);
      @(negedge ap_clk);
      #1;
      chk("rej_done_once", done, 0);
      chk("rej_busy_after", busy, 0);
      chk("rej_ce_after", mem_ce0, 0);
   endtask

   // One job: load nb random beats, replay np passes; optional mid-load
   // restart, ready stall window, or reset after abort_at output beats.
   task automatic run_job(input int nb, input int np, input int v_pct, input int r_pct,
                          input bit restart_in_load, input int stall_at, input int abort_at);
      logic [255:0] ld[$];
      int li = 0, rd_n = 0, mhs = 0, stall_cnt = 0, cyc = 0;
      bit restarted = 0, stalled = 0, prev_stall = 0, prev_last = 0, finished = 0;
      logic [255:0] prev_data = '0;
      ld.delete(); exp_q.delete(); exp_last_q.delete();
      for (int i = 0; i < nb; i++) ld.push_back(rand256());
      for (int p = 0; p < np; p++)
         for (int i = 0; i < nb; i++) begin
            exp_q.push_back(ld[i]);
            exp_last_q.push_back(i == nb - 1);
         end
      @(negedge ap_clk);
      start = 1'b1; num_beats = 12'(nb); passes = 8'(np);
      s_tvalid = 1'b0; m_tready = 1'b0;
      while (!finished) begin
         @(negedge ap_clk);
         cyc++;
         start = 1'b0;
         if (restart_in_load && !restarted && li == 2) begin
            start = 1'b1; num_beats = 12'd7; passes = 8'd1; restarted = 1;
         end
         if (abort_at >= 0 && mhs == abort_at) begin
            ap_rst_n = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
            @(negedge ap_clk);
            ap_rst_n = 1'b1;
            #1;
            chk_reset_values("abort");
            for (int k = 0; k < 5; k++) begin
               @(negedge ap_clk);
               #1;
               chk("abort_no_done", done, 0);
               chk("abort_idle", busy, 0);
            end
            return;
         end
         s_tvalid = (li < nb) && ($urandom_range(99) < v_pct);
         s_tdata  = (li < nb && s_tvalid) ? ld[li] : rand256();
         if (stall_at >= 0 && !stalled && mhs == stall_at) begin
            stall_cnt = 10; stalled = 1;
         end
         if (stall_cnt > 0) begin
            m_tready = 1'b0; stall_cnt--;
         end else begin
            m_tready = ($urandom_range(99) < r_pct);
         end
         #1;
         chk("wr_gate", mem_ce0 && mem_we0, s_tvalid && s_tready);
         if (s_tvalid && s_tready) begin
            chk("wr_addr", mem_address0, li);
            chk("wr_data", mem_d0, ld[li]);
            li++;
         end
         if (mem_ce0 && !mem_we0) begin
            chk("rd_after_load", li == nb, 1);
            chk("rd_addr", mem_address0, rd_n % nb);
            chk("rd_count", rd_n < nb * np, 1);
            rd_n++;
            chk("outstanding", (rd_n - mhs) <= 2, 1);
         end
         if (prev_stall) begin
            chk("stall_valid", m_tvalid, 1);
            chk("stall_data", m_tdata, prev_data);
            chk("stall_last", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) chk("extra_beat", 0, 1);
            else begin
               chk("m_tdata", m_tdata, exp_q.pop_front());
               chk("m_tlast", m_tlast, exp_last_q.pop_front());
            end
            mhs++;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         if (done) begin
            chk("done_busy", busy, 0);
            chk("done_beats_left", exp_q.size(), 0);
            chk("done_loaded", li, nb);
            chk("done_reads", rd_n, nb * np);
            @(negedge ap_clk);
            s_tvalid = 1'b0; m_tready = 1'b0;
            #1;
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            finished = 1;
         end else begin
            chk("busy_in_job", busy, 1);
            if (cyc > 30000) begin
               chk("timeout", 0, 1);
               finished = 1;
            end
         end
      end
   endtask

   initial begin
      ap_rst_n = 1'b0; start = 1'b0; num_beats = '0; passes = '0;
      s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
      repeat (3) @(negedge ap_clk);
      #1;
      chk_reset_values("reset");
      ap_rst_n = 1'b1;

      run_job(4, 2, 100, 100, 0, -1, -1);
      reject_start(0, 1);
      reject_start(2049, 1);
      reject_start(5, 0);
      run_job(5, 3, 80, 70, 1, -1, -1);
      run_job(6, 3, 100, 100, 0, -1, 3);
      run_job(1, 1, 100, 100, 0, -1, -1);
      run_job(8, 3, 70, 60, 0, 2, -1);
      run_job(2048, 1, 80, 30, 0, -1, -1);
      for (int t = 0; t < 3; t++)
         run_job($urandom_range(1, 40), $urandom_range(1, 4),
                 $urandom_range(50, 100), $urandom_range(30, 100), 0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
